// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle WIDTH-bit add/subtract built from one
// CHUNK-bit ripple slice and a registered carry, CHUNK bits per clock.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - operation request, sampled only while idle
//   a, b   - operands, captured on the accepting edge
//   cin    - carry-in (add) / borrow-in (sub), captured on the accepting edge
//   sub    - 0: a+b+cin, 1: a-b-cin, captured on the accepting edge
//   busy   - high while an operation is running or completing
//   done   - one-cycle pulse, result valid
//   sum    - registered result, updated only on completion
//   cout   - final carry; in subtract mode 1 means no borrow
//   ovf    - two's-complement signed overflow
module chunked_serial_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic               r_carry;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [IDX_W-1:0]   w_base;
  logic [CHUNK-1:0]   w_a_chk;
  logic [CHUNK-1:0]   w_b_chk;
  logic [CHUNK:0]     w_ext;
  logic [WIDTH-1:0]   w_merged;
  logic               w_ovf;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(NCHUNK - 1));

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; busy/done are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // One CHUNK-bit ripple slice selected by the chunk counter
  always_comb begin
    w_base   = IDX_W'(r_cnt * CHUNK);
    w_a_chk  = r_opa[w_base +: CHUNK];
    w_b_chk  = r_opb[w_base +: CHUNK];
    w_ext    = {1'b0, w_a_chk} + {1'b0, w_b_chk} + (CHUNK + 1)'(r_carry);
    w_merged = r_work;
    w_merged[w_base +: CHUNK] = w_ext[CHUNK-1:0];
    // Operand B is already inverted for subtract, so one rule covers both modes
    w_ovf    = (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
               (w_ext[CHUNK-1] != r_opa[WIDTH-1]);
  end

  // Operand capture, per-chunk accumulation and result publication
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_work  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= a;
      r_opb   <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_cnt   <= '0;
      r_work  <= '0;
    end else if (r_state == S_RUN) begin
      r_work  <= w_merged;
      r_carry <= w_ext[CHUNK];
      r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_merged;
        r_cout <= w_ext[CHUNK];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Multi-cycle, parametrised add/subtract unit. Generalises the single-bit full adder to a WIDTH-bit operand.
- Processes CHUNK bits per clock through one CHUNK-bit ripple slice and a registered carry.
- Start/busy/done handshake; signed-overflow flag.
- Used where area matters more than latency (accumulators, address generators in datapath blocks).

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits added per clock cycle. 1 <= CHUNK <= WIDTH.
- NCHUNK (derived localparam), WIDTH/CHUNK, number of RUN cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- cin  in  1  carry-in (add) or borrow-in (sub); captured on the accepting edge.
- sub  in  1  0 = a+b+cin, 1 = a-b-cin; captured on the accepting edge.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result, registered.
- cout  out  1  final carry. In sub mode, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE, chunk counter=0, working registers=0.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - A reset mid-operation aborts the operation: no done pulse, and no partial result reaches sum.
- States:
  - IDLE -> RUN on an edge with start=1.
  - RUN stays in RUN for NCHUNK edges, then -> DONE.
  - DONE -> IDLE after one cycle, unconditionally.
- Accept (edge where IDLE and start=1):
  - opA <= a.
  - opB <= sub ? ~b : b.
  - carry <= sub ? ~cin : cin.
  - cnt <= 0.
- RUN edge k (k = 0..NCHUNK-1):
  - {c, s} = opA[k*CHUNK +: CHUNK] + opB[k*CHUNK +: CHUNK] + carry.
  - work[k*CHUNK +: CHUNK] <= s; carry <= c; cnt <= cnt+1.
  - On k = NCHUNK-1, also record ovf_w = (opA[WIDTH-1] == opB[WIDTH-1]) && (s[CHUNK-1] != opA[WIDTH-1]).
  - Leaving RUN: sum <= work with the final chunk merged in; cout <= final carry; ovf <= ovf_w.
- DONE: done=1 for exactly one cycle.
- Output timing:
  - sum/cout/ovf change only on the edge entering DONE.
  - They hold their previous values throughout RUN and until the next completion.
- Latency: done is high in the cycle after the (NCHUNK+1)th edge, counting the accepting edge as edge 1. Example: WIDTH=32, CHUNK=8 gives accept + 4 RUN edges, so done is high in the 5th cycle after the start sample.
- Throughput: one operation per NCHUNK+2 cycles. start is ignored while busy=1, including the DONE cycle. A start held high is re-accepted on the first IDLE edge.
- Arithmetic: all operations are modulo 2^WIDTH. Input changes after acceptance have no effect.
- CHUNK=WIDTH (NCHUNK=1): one RUN cycle; the same rules apply.
- Counter width: clog2(NCHUNK), minimum 1 bit. It wraps to 0 on leaving RUN.

Test Plan:
- WIDTH=32, CHUNK=8, add:
  - a=0x0000_00FF, b=0x0000_0001, cin=0 -> sum=0x0000_0100, cout=0, ovf=0.
  - done pulses exactly once, 5 cycles after start; busy is high for cycles 1-5.
- Carry chain through every chunk: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, ovf=0.
- Signed overflow, both directions:
  - add a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, ovf=1, cout=0.
  - sub a=0x8000_0000, b=1, cin=0 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
- Subtract with borrow: sub=1, a=5, b=7, cin=1 -> sum=0xFFFF_FFFD, cout=0, ovf=0.
- Handshake and reset:
  - Pulse start again during RUN and during DONE -> ignored, no second done.
  - Hold start high -> back-to-back operations every 6 cycles.
  - Drive rst_n=0 on RUN edge 2 -> next cycle busy=0, sum=0, no done.
- Parameter sweep: CHUNK=1, 4, 32 with WIDTH=32; 1000 random a/b/cin/sub vectors each.
  - Results must match the reference model (a ± b ± cin) mod 2^32, with matching cout/ovf.
  - done latency must equal NCHUNK+1 cycles.
